// File: rtl/cov_result_collector.sv
// Result collector for the covariance systolic array.
// Captures PE result words by (row, col) while idle, then drains the N x N
// matrix row-major over a valid/ready stream after frame_done.
// Optional build macro: COV_SYMM_MIRROR_EN stores only the upper triangle
// and serves lower-triangle reads from the transposed entry.
module cov_result_collector #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [1:0]        cap_row,
  input  logic [1:0]        cap_col,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              frame_done,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_row,
  output logic [1:0]        out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned DEPTH  = N * N;
  localparam int unsigned ADDR_W = 4;
  localparam logic [1:0]  LAST_IDX = 2'(N - 1);
  localparam logic [2:0]  N_EXT    = 3'(N);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              in_range;
  logic              wr_keep;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              at_last;
  logic [1:0]        rd_row, rd_col;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Capture address decode and symmetric-store filtering
  always_comb begin
    in_range = ({1'b0, cap_row} < N_EXT) && ({1'b0, cap_col} < N_EXT);
`ifdef COV_SYMM_MIRROR_EN
    wr_keep  = (cap_row <= cap_col);
`else
    wr_keep  = 1'b1;
`endif
    wr_addr  = ADDR_W'(cap_row) * ADDR_W'(N) + ADDR_W'(cap_col);
    at_last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  end

  // Drain read address (lower triangle folds onto upper when mirrored) and mux
  always_comb begin
    rd_row = row_q;
    rd_col = col_q;
`ifdef COV_SYMM_MIRROR_EN
    if (row_q > col_q) begin
      rd_row = col_q;
      rd_col = row_q;
    end
`endif
    rd_addr = ADDR_W'(rd_row) * ADDR_W'(N) + ADDR_W'(rd_col);
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = mem_q[i];
    end
  end

  // Next-state: capture/overflow in IDLE, pointer walk in DRAIN
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    mem_d      = mem_q;

    case (state_q)
      ST_IDLE: begin
        if (cap_en) begin
          if (!in_range) overflow_d = 1'b1;
          else if (wr_keep) wr_en = 1'b1;
        end
        if (frame_done) begin
          state_d = ST_DRAIN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cap_en || frame_done) overflow_d = 1'b1;
        if (out_ready) begin
          if (at_last) begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) mem_d[i] = cap_data;
    end
  end

  // State, pointer, sticky flag and matrix storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Outputs decoded from registered state and pointer only
  assign busy      = (state_q == ST_DRAIN);
  assign out_valid = busy;
  assign out_last  = busy && at_last;
  assign out_data  = busy ? rd_data : '0;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cov_result_collector.sv
// Scoreboard bench for cov_result_collector (N=2, DATA_W=16).
module tb_cov_result_collector;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cap_en = 1'b0;
  logic [1:0]        cap_row = '0;
  logic [1:0]        cap_col = '0;
  logic [DATA_W-1:0] cap_data = '0;
  logic              frame_done = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  cov_result_collector #(.N(2), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cap_en(cap_en), .cap_row(cap_row), .cap_col(cap_col), .cap_data(cap_data),
    .frame_done(frame_done),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every handshake against the scoreboard and checks stall hold
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] sv_data;
  logic [1:0]        sv_row, sv_col;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(sv_data));
        chk("stall_row", 32'(out_row), 32'(sv_row));
        chk("stall_col", 32'(out_col), 32'(sv_col));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %0h row %0d col %0d expected none", out_data, out_row, out_col);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_row", 32'(out_row), 32'(e.row));
          chk("out_col", 32'(out_col), 32'(e.col));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      sv_data    = out_data;
      sv_row     = out_row;
      sv_col     = out_col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [1:0] r, input logic [1:0] c, input logic [DATA_W-1:0] d);
    cap_en = 1'b1; cap_row = r; cap_col = c; cap_data = d;
    tick();
    cap_en = 1'b0;
  endtask

  task automatic frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic run_ready(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  // Expected stream in row-major order; mirrored build reads (1,0) from (0,1)
  task automatic push_frame(input logic [DATA_W-1:0] e00, input logic [DATA_W-1:0] e01,
                            input logic [DATA_W-1:0] e10, input logic [DATA_W-1:0] e11);
    logic [DATA_W-1:0] v10;
`ifdef COV_SYMM_MIRROR_EN
    v10 = e01;
`else
    v10 = e10;
`endif
    exp_q.push_back('{data: e00, row: 2'd0, col: 2'd0, last: 1'b0});
    exp_q.push_back('{data: e01, row: 2'd0, col: 2'd1, last: 1'b0});
    exp_q.push_back('{data: v10, row: 2'd1, col: 2'd0, last: 1'b0});
    exp_q.push_back('{data: e11, row: 2'd1, col: 2'd1, last: 1'b1});
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic pat [7];

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_row", 32'(out_row), 32'd0);
    chk("rst_col", 32'(out_col), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame, full-rate drain
    cap(2'd0, 2'd0, 16'd1);
    cap(2'd1, 2'd0, 16'd2);
    cap(2'd0, 2'd1, 16'd3);
    cap(2'd1, 2'd1, 16'd4);
    push_frame(16'd1, 16'd3, 16'd2, 16'd4);
    out_ready = 1'b1;
    frame();
    chk("drain_start_valid", 32'(out_valid), 32'd1);
    chk("drain_start_busy", 32'(busy), 32'd1);
    chk("drain_start_row", 32'(out_row), 32'd0);
    chk("drain_start_col", 32'(out_col), 32'd0);
    run_ready(4);
    chk_idle("full_rate_end");

    // Same frame with backpressure
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    push_frame(16'd1, 16'd3, 16'd2, 16'd4);
    frame();
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b0;
    chk_idle("stall_end");

    // Capture coincident with frame_done is visible to the drain
    push_frame(16'd1, 16'd3, 16'd2, 16'h00AA);
    cap_en = 1'b1; cap_row = 2'd1; cap_col = 2'd1; cap_data = 16'h00AA;
    frame_done = 1'b1;
    tick();
    cap_en = 1'b0; frame_done = 1'b0;
    run_ready(4);
    chk_idle("same_cycle_end");
    chk("same_cycle_ovf", 32'(overflow), 32'd0);

    // Capture during drain: ignored, overflow sticky
    push_frame(16'd1, 16'd3, 16'd2, 16'h00AA);
    frame();
    cap(2'd0, 2'd0, 16'hFFFF);
    chk("drain_cap_ovf", 32'(overflow), 32'd1);
    run_ready(4);
    chk_idle("drain_cap_end");
    push_frame(16'd1, 16'd3, 16'd2, 16'h00AA);
    frame();
    run_ready(4);
    chk_idle("old_value_end");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-drain after the second handshake
    push_frame(16'd1, 16'd3, 16'd2, 16'h00AA);
    frame();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();
    cap(2'd0, 2'd1, 16'd5);
    push_frame(16'd0, 16'd5, 16'd0, 16'd0);
    frame();
    run_ready(4);
    chk_idle("post_rst_end");

    // Out-of-range capture is dropped and flagged
    cap(2'd2, 2'd1, 16'h1234);
    chk("oor_ovf", 32'(overflow), 32'd1);
    push_frame(16'd0, 16'd5, 16'd0, 16'd0);
    frame();
    run_ready(4);
    chk_idle("oor_end");

`ifdef COV_SYMM_MIRROR_EN
    // Lower-triangle capture is silently dropped; read mirrors the upper entry
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cap(2'd0, 2'd1, 16'd7);
    cap(2'd1, 2'd0, 16'd9);
    chk("mirror_ovf", 32'(overflow), 32'd0);
    push_frame(16'd0, 16'd7, 16'd7, 16'd0);
    frame();
    run_ready(4);
    chk_idle("mirror_end");
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cov_result_collector.md
# cov_result_collector

Result collector for the covariance systolic array. During the compute phase it captures one partial-product/accumulator word per cycle from the PE grid, addressed by the control unit's current row and column. When the control unit pulses done, it drains the N×N covariance matrix in row-major order over a valid/ready stream to the downstream eigen/PCA stage.

## Interface
- N, 2, matrix dimension; legal range 1..4 (row/col ports are 2 bits wide).
- DATA_W, 16, width of a covariance element.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cap_en  in  1  capture strobe; driven by the control unit's pe_enable.
- cap_row  in  2  row index of cap_data (current_row).
- cap_col  in  2  column index of cap_data (current_col).
- cap_data  in  DATA_W  PE result word.
- frame_done  in  1  single-cycle end-of-frame pulse (control unit done).
- out_data  out  DATA_W  matrix element being presented.
- out_row  out  2  row index of out_data.
- out_col  out  2  column index of out_data.
- out_valid  out  1  out_data, out_row and out_col are valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_last  out  1  high with out_valid on element (N-1, N-1).
- busy  out  1  high while in DRAIN.
- overflow  out  1  sticky error flag.

## Operation
- Storage: N*N × DATA_W register array, address = row*N + col. Reset clears all entries to 0.
- FSM states are IDLE and DRAIN. Reset state is IDLE.
- IDLE:
  - cap_en=1 with cap_row<N and cap_col<N writes cap_data to mem[row*N+col].
  - Out-of-range indices: the write is dropped and overflow is set.
  - frame_done=1 moves to DRAIN with ptr=0. A capture in the same cycle is committed first, so the drain sees it.
- DRAIN:
  - out_valid=1, out_data=mem[ptr], out_row=ptr/N, out_col=ptr%N.
  - On each handshake ptr increments. A handshake at ptr=N*N-1 (out_last) returns to IDLE.
  - Without a handshake, out_data, out_row and out_col stay stable.
- Captures and frame_done arriving in DRAIN are ignored: memory is unchanged and overflow is set.
- overflow is cleared only by rst.
- Entries not written during a frame keep their previous-frame value. No per-frame clear.
- Reset mid-drain: the next cycle shows out_valid=0, busy=0, ptr=0, memory all zero.

## Timing
- Reset values: out_valid=0, out_last=0, busy=0, overflow=0, out_data=0, out_row=0, out_col=0.
- Write latency is 1 cycle: data captured at edge k is readable on the drain from edge k+1.
- frame_done sampled at edge k gives out_valid=1 from edge k onward, with the first element (0,0).
- Minimum drain time is N*N cycles with out_ready held high. Throughput is 1 element per cycle.
- The first frame_done accepted after DRAIN→IDLE may arrive on the cycle immediately after the last handshake.
- The outputs out_valid, out_last and busy are decoded from registered state and ptr only. There is no combinational path from out_ready to out_valid.

## Configuration
- COV_SYMM_MIRROR_EN defined:
  - Only the upper triangle is stored; captures with row>col are dropped without setting overflow.
  - During DRAIN, element (r,c) with r>c returns mem[c*N+r].
- COV_SYMM_MIRROR_EN undefined:
  - All N*N entries are written and read directly.
- Port list, FSM and timing are identical in both builds.

## Test plan
- N=2, captures (0,0)=1, (1,0)=2, (0,1)=3, (1,1)=4, then frame_done, out_ready=1 → stream 1,3,2,4 on 4 consecutive cycles; out_last high only with 4; then busy=0.
- Same frame with out_ready toggling 1,0,0,1,1,0,1 → each element held stable while stalled; exactly 4 handshakes in order.
- Capture on the same cycle as frame_done, to (1,1)=0x00AA → last drained element is 0x00AA.
- cap_en during DRAIN (data 0xFFFF at (0,0)) → overflow=1 sticky; the next frame still reads the old (0,0) value.
- rst asserted after the 2nd handshake → out_valid=0 and overflow=0 next cycle; a fresh frame drains from (0,0) with unwritten entries reading 0.
- COV_SYMM_MIRROR_EN, captures (0,1)=7 and (1,0)=9 → overflow stays 0; the drain outputs 7 for both (0,1) and (1,0).
